// File: rtl/cpu_pkg.sv
// Shared types and default sizing for the parametrised accumulator CPU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ADDR_W      = 4;
    localparam int DEF_STACK_DEPTH = 8;
    localparam int DEF_MAX_STEPS   = 16;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_XCHG = 4'h2,
        OP_MOV  = 4'h3,
        OP_ROR  = 4'h4,
        OP_IN   = 4'h5,
        OP_OUT  = 4'h6,
        OP_AND  = 4'h7,
        OP_CLRF = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_PUSH = 4'hB,
        OP_POP  = 4'hC,
        OP_ROL  = 4'hD,
        OP_NOT  = 4'hE,
        OP_HLT  = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Width of the accepted-instruction counter; never narrower than one bit.
    function automatic int step_w(input int max_steps);
        return (max_steps == 0) ? 1 : $clog2(max_steps + 1);
    endfunction

endpackage

// File: rtl/cpu_stack.sv
// Bounded LIFO holding data words; sp counts occupied entries.
// Latency: push/pop take effect on the clock edge, top is combinational from sp.
// Backpressure: none; push when full or pop when empty is ignored and flagged on err.
module cpu_stack #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] top,
    output logic              full,
    output logic              empty,
    output logic              err
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0]   sp;
    logic [DATA_W-1:0] store [DEPTH];
    logic [IDX_W-1:0]  top_idx;

    assign full    = (sp == SP_W'(DEPTH));
    assign empty   = (sp == '0);
    assign err     = (push && full) || (pop && empty);
    assign top_idx = IDX_W'(sp - SP_W'(1));
    assign top     = empty ? '0 : store[top_idx];

    // Stack pointer: the only reset state; contents survive reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Storage write on a successful push.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            store[IDX_W'(sp)] <= data;
        end
    end

endmodule

// File: rtl/param_acc_cpu.sv
// Single-issue memory-operand CPU: INIT fills mem[i]=i, RUN executes, HALT is terminal.
// Latency: instruction accepted at edge N has dout/flags/memory updated after edge N.
// Backpressure: instr_ready low during INIT, HALT, and once MAX_STEPS instructions are taken.
module param_acc_cpu
    import cpu_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int MAX_STEPS   = DEF_MAX_STEPS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic [3:0]                    opcode,
    input  logic [ADDR_W-1:0]             address,
    input  logic [DATA_W-1:0]             din,
    output logic [DATA_W-1:0]             dout,
    output logic                          dout_valid,
    output logic                          halt,
    output logic                          s_flag,
    output logic                          z_flag,
    output logic                          c_flag,
    output logic                          stk_err,
    output logic [step_w(MAX_STEPS)-1:0]  step_count
);

    localparam int              SC_W      = step_w(MAX_STEPS);
    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [SC_W-1:0] STEP_LIM  = SC_W'(MAX_STEPS);
    localparam bit              UNLIMITED = (MAX_STEPS == 0);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] init_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    opcode_t           op;
    logic              accept;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] m;
    logic [DATA_W-1:0] m_p1;

    logic [DATA_W-1:0] res;
    logic              c_new;
    logic              upd_flags;
    logic              mem_we;
    logic              emit;

    logic [DATA_W-1:0] stk_top;
    logic              stk_full_unused;
    logic              stk_empty;
    logic              stk_op_err;

    assign op          = opcode_t'(opcode);
    assign instr_ready = (state == ST_RUN) && (UNLIMITED || (step_count != STEP_LIM));
    assign accept      = instr_valid && instr_ready;
    assign addr_p1     = address + ADDR_W'(1);
    assign m           = mem[address];
    assign m_p1        = mem[addr_p1];

    cpu_stack #(
        .DATA_W (DATA_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (accept && (op == OP_PUSH)),
        .pop   (accept && (op == OP_POP)),
        .data  (m),
        .top   (stk_top),
        .full  (stk_full_unused),
        .empty (stk_empty),
        .err   (stk_op_err)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: INIT walks every address once, HLT parks the core.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (init_idx == '1) state_nxt = ST_RUN;
            ST_RUN:  if (accept && (op == OP_HLT)) state_nxt = ST_HALT;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_INIT;
        endcase
    end

    // INIT address walker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_idx <= '0;
        end else if (state == ST_INIT) begin
            init_idx <= init_idx + ADDR_W'(1);
        end
    end

    // Execute: result, write-back enable and flag source for the current opcode.
    always_comb begin
        res       = m;
        c_new     = 1'b0;
        upd_flags = 1'b0;
        mem_we    = 1'b0;
        emit      = 1'b1;
        case (op)
            OP_ADD:  begin {c_new, res} = {1'b0, m} + {1'b0, din}; upd_flags = 1'b1; end
            OP_SUB:  begin res = m - din; c_new = (m < din); upd_flags = 1'b1; end
            OP_XCHG: begin res = m_p1; mem_we = 1'b1; end
            OP_MOV:  begin res = mem[0]; mem_we = 1'b1; end
            OP_ROR:  begin res = {m[0], m[DATA_W-1:1]}; c_new = m[0]; upd_flags = 1'b1; mem_we = 1'b1; end
            OP_IN:   begin res = din; mem_we = 1'b1; end
            OP_OUT:  res = m;
            OP_AND:  begin res = m & din; upd_flags = 1'b1; mem_we = 1'b1; end
            OP_CLRF: res = m;
            OP_OR:   begin res = m | din; upd_flags = 1'b1; mem_we = 1'b1; end
            OP_XOR:  begin res = m ^ din; upd_flags = 1'b1; mem_we = 1'b1; end
            OP_PUSH: res = m;
            OP_POP:  begin res = stk_empty ? '0 : stk_top; mem_we = !stk_empty; end
            OP_ROL:  begin res = {m[DATA_W-2:0], m[DATA_W-1]}; c_new = m[DATA_W-1]; upd_flags = 1'b1; mem_we = 1'b1; end
            OP_NOT:  begin res = ~m; upd_flags = 1'b1; mem_we = 1'b1; end
            OP_HLT:  emit = 1'b0;
            default: emit = 1'b0;
        endcase
    end

    // Operand memory: identity fill during INIT, write-back during RUN.
    // XCHG additionally stores the old mem[a] into mem[a+1] (wrapping to 0).
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_idx] <= DATA_W'(init_idx);
        end else if (accept) begin
            if (mem_we) mem[address] <= res;
            if (op == OP_XCHG) mem[addr_p1] <= m;
        end
    end

    // Architectural outputs: result, pulse, flags, sticky halt/stack error, step counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            halt       <= 1'b0;
            s_flag     <= 1'b0;
            z_flag     <= 1'b0;
            c_flag     <= 1'b0;
            stk_err    <= 1'b0;
            step_count <= '0;
        end else begin
            dout_valid <= accept && emit;
            if (accept) begin
                if (step_count != '1) step_count <= step_count + SC_W'(1);
                if (emit) dout <= res;
                if (op == OP_HLT) halt <= 1'b1;
                if (upd_flags) begin
                    s_flag <= res[DATA_W-1];
                    z_flag <= (res == '0);
                    c_flag <= c_new;
                end
                if (op == OP_CLRF) begin
                    s_flag  <= 1'b0;
                    z_flag  <= 1'b0;
                    c_flag  <= 1'b0;
                    stk_err <= 1'b0;
                end else if (stk_op_err) begin
                    stk_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_acc_cpu.sv
module tb_param_acc_cpu;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] opcode = 4'h0;
    logic [3:0] address = 4'h0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       dout_valid;
    logic       halt;
    logic       s_flag;
    logic       z_flag;
    logic       c_flag;
    logic       stk_err;
    logic [4:0] step_count;

    param_acc_cpu dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .address     (address),
        .din         (din),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .halt        (halt),
        .s_flag      (s_flag),
        .z_flag      (z_flag),
        .c_flag      (c_flag),
        .stk_err     (stk_err),
        .step_count  (step_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] dout;
        logic       s;
        logic       z;
        logic       c;
        logic       err;
    } vec_t;

    vec_t vt [48];
    int   nv = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic add_vec(input logic [3:0] o, input logic [3:0] a, input logic [7:0] d,
                           input logic [7:0] exp_dout, input logic s, input logic z,
                           input logic c, input logic err);
        vt[nv].op   = o;
        vt[nv].a    = a;
        vt[nv].d    = d;
        vt[nv].dout = exp_dout;
        vt[nv].s    = s;
        vt[nv].z    = z;
        vt[nv].c    = c;
        vt[nv].err  = err;
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        instr_valid = 1'b1;
        opcode      = o;
        address     = a;
        din         = d;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_dout"},       32'(dout),       32'h0);
        chk({tag, "_dout_valid"}, 32'(dout_valid), 32'h0);
        chk({tag, "_halt"},       32'(halt),       32'h0);
        chk({tag, "_s"},          32'(s_flag),     32'h0);
        chk({tag, "_z"},          32'(z_flag),     32'h0);
        chk({tag, "_c"},          32'(c_flag),     32'h0);
        chk({tag, "_stk_err"},    32'(stk_err),    32'h0);
        chk({tag, "_step_count"}, 32'(step_count), 32'h0);
        chk({tag, "_ready"},      32'(instr_ready), 32'h0);
    endtask

    // Asserts reset off-edge, checks outputs immediately, then releases and times INIT.
    task automatic do_reset(input string tag);
        int bad;
        #1;
        rst         = 1'b0;
        instr_valid = 1'b0;
        #1;
        check_reset_vals(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (instr_ready !== 1'b0) bad++;
        end
        chk({tag, "_init_ready_low_cycles_bad"}, 32'(bad), 32'h0);
        @(posedge clk);
        #1;
        chk({tag, "_init_ready_rise"}, 32'(instr_ready), 32'h1);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            issue(vt[i].op, vt[i].a, vt[i].d);
            chk($sformatf("v%0d_dout", i),       32'(dout),       32'(vt[i].dout));
            chk($sformatf("v%0d_dout_valid", i), 32'(dout_valid), 32'h1);
            chk($sformatf("v%0d_s", i),          32'(s_flag),     32'(vt[i].s));
            chk($sformatf("v%0d_z", i),          32'(z_flag),     32'(vt[i].z));
            chk($sformatf("v%0d_c", i),          32'(c_flag),     32'(vt[i].c));
            chk($sformatf("v%0d_stk_err", i),    32'(stk_err),    32'(vt[i].err));
        end
    endtask

    // Holds a valid OUT a=5 for three cycles while the core must refuse it.
    task automatic refused_instr(input string tag, output int dv_seen);
        dv_seen = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        opcode      = OP_OUT;
        address     = 4'd5;
        din         = 8'h00;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (dout_valid !== 1'b0) dv_seen++;
        end
        instr_valid = 1'b0;
        chk({tag, "_dout_valid_cycles"}, 32'(dv_seen), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dv_seen;

        // Run 1: arithmetic, logic, rotates, XCHG wrap, MOV, step limit.
        //       op       a      din    dout   s  z  c  err
        add_vec(OP_OUT,  4'd5,  8'h00, 8'h05, 0, 0, 0, 0);
        add_vec(OP_ADD,  4'd15, 8'hF5, 8'h04, 0, 0, 1, 0);
        add_vec(OP_SUB,  4'd3,  8'h05, 8'hFE, 1, 0, 1, 0);
        add_vec(OP_XCHG, 4'd15, 8'h00, 8'h00, 1, 0, 1, 0);
        add_vec(OP_OUT,  4'd0,  8'h00, 8'h0F, 1, 0, 1, 0);
        add_vec(OP_IN,   4'd1,  8'h80, 8'h80, 1, 0, 1, 0);
        add_vec(OP_ROL,  4'd1,  8'h00, 8'h01, 0, 0, 1, 0);
        add_vec(OP_ROR,  4'd1,  8'h00, 8'h80, 1, 0, 1, 0);
        add_vec(OP_AND,  4'd2,  8'h00, 8'h00, 0, 1, 0, 0);
        add_vec(OP_OR,   4'd2,  8'hA5, 8'hA5, 1, 0, 0, 0);
        add_vec(OP_XOR,  4'd2,  8'hFF, 8'h5A, 0, 0, 0, 0);
        add_vec(OP_NOT,  4'd2,  8'h00, 8'hA5, 1, 0, 0, 0);
        add_vec(OP_SUB,  4'd4,  8'h04, 8'h00, 0, 1, 0, 0);
        add_vec(OP_MOV,  4'd6,  8'h00, 8'h0F, 0, 1, 0, 0);
        add_vec(OP_OUT,  4'd6,  8'h00, 8'h0F, 0, 1, 0, 0);
        add_vec(OP_ADD,  4'd7,  8'hF9, 8'h00, 0, 1, 1, 0);
        // Run 2: overflow on the ninth push, CLRF, then flags left set before reset.
        for (int i = 0; i < 8; i++) add_vec(OP_PUSH, 4'(i), 8'h00, 8'(i), 0, 0, 0, 0);
        add_vec(OP_PUSH, 4'd8,  8'h00, 8'h08, 0, 0, 0, 1);
        add_vec(OP_CLRF, 4'd3,  8'h00, 8'h03, 0, 0, 0, 0);
        add_vec(OP_ADD,  4'd15, 8'h80, 8'h8F, 1, 0, 0, 0);
        // Run 3: fill the stack and drain it in LIFO order.
        for (int i = 1; i <= 8; i++) add_vec(OP_PUSH, 4'(i), 8'h00, 8'(i), 0, 0, 0, 0);
        for (int i = 8; i >= 1; i--) add_vec(OP_POP, 4'd0, 8'h00, 8'(i), 0, 0, 0, 0);
        // Run 4: underflow, sticky error, CLRF, then a result to hold across HLT.
        add_vec(OP_POP,  4'd5,  8'h00, 8'h00, 0, 0, 0, 1);
        add_vec(OP_POP,  4'd5,  8'h00, 8'h00, 0, 0, 0, 1);
        add_vec(OP_OUT,  4'd5,  8'h00, 8'h05, 0, 0, 0, 1);
        add_vec(OP_CLRF, 4'd5,  8'h00, 8'h05, 0, 0, 0, 0);
        add_vec(OP_ADD,  4'd5,  8'hFA, 8'hFF, 1, 0, 0, 0);

        #3;
        do_reset("rst1");
        run_vecs(0, 15);
        chk("limit_step_count", 32'(step_count), 32'd16);
        chk("limit_ready",      32'(instr_ready), 32'h0);
        refused_instr("limit", dv_seen);
        chk("limit_dout_held",  32'(dout),       32'h00);
        chk("limit_step_held",  32'(step_count), 32'd16);
        chk("limit_no_halt",    32'(halt),       32'h0);

        do_reset("rst2");
        run_vecs(16, 26);
        // Mid-run reset: dout=0x8F and s=1 must clear at once.
        do_reset("midrun");
        run_vecs(27, 42);
        chk("stack_run_step_count", 32'(step_count), 32'd16);

        do_reset("rst4");
        run_vecs(43, 47);
        issue(OP_HLT, 4'd0, 8'h00);
        chk("hlt_halt",       32'(halt),        32'h1);
        chk("hlt_dout_valid", 32'(dout_valid),  32'h0);
        chk("hlt_dout_held",  32'(dout),        32'hFF);
        chk("hlt_s_held",     32'(s_flag),      32'h1);
        chk("hlt_ready",      32'(instr_ready), 32'h0);
        chk("hlt_step_count", 32'(step_count),  32'd6);
        refused_instr("halted", dv_seen);
        chk("halted_dout_held", 32'(dout),       32'hFF);
        chk("halted_step_held", 32'(step_count), 32'd6);
        chk("halted_halt_held", 32'(halt),       32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_acc_cpu.md
# param_acc_cpu

Parametrised successor to the 4-bit-address teaching CPU: a single-issue, memory-operand processor with generic data width, address width and stack depth. It accepts one instruction per cycle over a valid/ready handshake and executes it in one cycle against an internal register file. It adds:
- a reset-time memory initialisation sequence,
- a bounded LIFO stack with error detection,
- correct borrow/sign semantics,
- true rotates,
- a sticky halt.

It sits between the instruction sequencer and the output display/register logic.

## Interface
- DATA_W, 8, operand/result width (≥2)
- ADDR_W, 4, memory address width; memory depth 2^ADDR_W
- STACK_DEPTH, 8, LIFO entries (≥1)
- MAX_STEPS, 16, instructions accepted before ready drops permanently; 0 = unlimited
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  block can accept
- opcode  in  4  operation code
- address  in  ADDR_W  memory operand index
- din  in  DATA_W  immediate/input data
- dout  out  DATA_W  registered result
- dout_valid  out  1  one-cycle pulse, dout updated
- halt  out  1  sticky halt
- s_flag, z_flag, c_flag  out  1 each  sign, zero, carry/borrow
- stk_err  out  1  sticky stack overflow/underflow
- step_count  out  clog2(MAX_STEPS+1) (min 1)  accepted instructions, saturating

## Operation
- States:
  - INIT: write mem[i]=i (truncated to DATA_W), one entry per cycle, i=0..2^ADDR_W-1, then go to RUN.
  - RUN: execute accepted instructions.
  - HALT: terminal until reset.
- instr_ready = (state==RUN) && (MAX_STEPS==0 || step_count<MAX_STEPS).
- Accept = instr_valid && instr_ready; step_count increments per accept.
- Let m = mem[address] and r = the result. Unless stated otherwise, dout=r.
  - 0 ADD: r=m+din; c=carry out; mem unchanged.
  - 1 SUB: r=m−din mod 2^DATA_W; c=(m<din).
  - 2 XCHG: swap mem[a] and mem[a+1]; a+1 wraps mod 2^ADDR_W; dout=old mem[a+1].
  - 3 MOV: mem[a]=mem[0]; dout=mem[0].
  - 4 ROR: mem[a]={m[0],m[MSB:1]}; c=m[0].
  - 5 IN: mem[a]=din.
  - 6 OUT: dout=m.
  - 7 AND / 9 OR / A XOR: mem[a]=m op din; c=0.
  - 8 CLRF: s,z,c,stk_err ← 0; dout=m.
  - B PUSH: if sp==STACK_DEPTH then stk_err=1 and the stack is unchanged; else stack[sp]=m and sp++. dout=m.
  - C POP: if sp==0 then stk_err=1, mem unchanged, dout=0; else sp−−, mem[a]=stack[sp−1], dout=that value.
  - D ROL: mem[a]={m[MSB−1:0],m[MSB]}; c=m[MSB].
  - E NOT: mem[a]=~m; c=0.
  - F HLT: halt=1, go to HALT; no dout_valid.
- Flag updates:
  - Opcodes 0,1,4,7,9,A,D,E: z=(r==0), s=r[MSB], c as listed.
  - All other opcodes leave s/z/c unchanged, except CLRF.
- XCHG with ADDR_W such that a==a+1 cannot occur; the wrap at a=2^ADDR_W−1 swaps with entry 0.
- Stack contents persist across reset; sp resets to 0.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - dout=0, dout_valid=0, halt=0, s/z/c=0, stk_err=0, step_count=0, sp=0
  - state=INIT, instr_ready=0
- INIT lasts exactly 2^ADDR_W cycles after reset release; instr_ready rises on the following cycle.
- Latency: an instruction accepted at edge N has its dout, flags, memory and dout_valid visible after edge N. dout_valid is high for that one cycle only.
- Back-to-back accepts are allowed every cycle. A following instruction reads memory as written by its predecessor; no hazards.
- Reset asserted mid-INIT or mid-RUN aborts immediately and restarts INIT.
- After HLT is accepted, instr_ready=0 from the next cycle; further valid instructions are ignored.
- At step_count==MAX_STEPS, instr_ready=0; halt is not asserted.

## Structure
- Package cpu_pkg holds:
  - opcode enum (OP_ADD…OP_HLT)
  - state enum (ST_INIT, ST_RUN, ST_HALT)
  - default width constants
- Sub-module cpu_stack: parametrised LIFO.
  - Inputs: push, pop, data.
  - Outputs: top, full, empty, err.
  - Owns sp.

## Test plan
- Reset release → instr_ready low for 16 cycles (ADDR_W=4), then high; OUT a=5 → dout=5, dout_valid pulse.
- ADD a=15 din=0xF5 → dout=0x04, c=1, z=0, s=0; SUB a=3 din=5 → dout=0xFE, c=1, s=1.
- XCHG a=15 → dout=0; next OUT a=0 → dout=15.
- 9 PUSH with STACK_DEPTH=8 → ninth sets stk_err=1; 8 POPs succeed; a further POP → dout=0, stk_err stays 1; CLRF → stk_err=0.
- ROL a=0x80 (after IN din=0x80) → dout=0x01, c=1; ROR → dout=0x80, c=1.
- HLT → halt=1, instr_ready=0; 17 instructions with MAX_STEPS=16 → only 16 accepted; rst low mid-run → all outputs at reset values immediately.
